// File: rtl/tft_tcon_gen_if.sv
// rtl/tft_tcon_gen_if.sv - panel-side signal bundle for the TFT timing controller
// LR/UD scan-direction inputs exist only when TCON_SCAN_DIR_EN is defined.
interface tft_tcon_gen_if #(
   parameter int CW = 9
);
   logic          EN;
`ifdef TCON_SCAN_DIR_EN
   logic          LR;
   logic          UD;
`endif
   logic          CLK_PIX;
   logic          PIX_CE;
   logic          STH;
   logic          OEH;
   logic          CKV;
   logic          OEV;
   logic          STV;
   logic          DE;
   logic          FRAME_START;
   logic          BUSY;
   logic [CW-1:0] hdata;
   logic [CW-1:0] vdata;

`ifdef TCON_SCAN_DIR_EN
   modport master (
      input  EN, LR, UD,
      output CLK_PIX, PIX_CE, STH, OEH, CKV, OEV, STV, DE, FRAME_START, BUSY, hdata, vdata
   );
   modport slave (
      output EN, LR, UD,
      input  CLK_PIX, PIX_CE, STH, OEH, CKV, OEV, STV, DE, FRAME_START, BUSY, hdata, vdata
   );
`else
   modport master (
      input  EN,
      output CLK_PIX, PIX_CE, STH, OEH, CKV, OEV, STV, DE, FRAME_START, BUSY, hdata, vdata
   );
   modport slave (
      output EN,
      input  CLK_PIX, PIX_CE, STH, OEH, CKV, OEV, STV, DE, FRAME_START, BUSY, hdata, vdata
   );
`endif
endinterface

// File: rtl/tft_tcon_gen.sv
// rtl/tft_tcon_gen.sv - TFT panel timing generator (pixel divider, h/v scan, registered decode)
// Optional scan mirroring of hdata/vdata is enabled by defining TCON_SCAN_DIR_EN.
module tft_tcon_gen #(
   parameter int DIV     = 12,
   parameter int H_TOTAL = 482,
   parameter int V_TOTAL = 241,
   parameter int H_ACT   = 480,
   parameter int V_ACT   = 240,
   parameter int CW      = 9
) (
   input  logic           CLK120,
   input  logic           RST_N,
   tft_tcon_gen_if.master bus
);
   localparam int            DW       = $clog2(DIV);
   localparam logic [DW-1:0] CNT_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] CNT_HALF = DW'(DIV / 2);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
   localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
   localparam logic [CW-1:0] ONE      = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   logic [DW-1:0] cnt;
   logic [DW-1:0] cnt_nxt;
   logic          clk_pix;
   logic          pix_ce;

   state_t        state;
   logic [CW-1:0] h;
   logic [CW-1:0] v;

   logic          sth;
   logic          oeh;
   logic          ckv;
   logic          stv;
   logic          de;
   logic          frame_start;
   logic [CW-1:0] hdata;
   logic [CW-1:0] vdata;

   logic          line_end;
   logic          frame_top;
   logic          frame_end;
   logic          de_nxt;
   logic [CW-1:0] h_step;
   logic [CW-1:0] v_step;
   logic [CW-1:0] hd_nxt;
   logic [CW-1:0] vd_nxt;

`ifdef TCON_SCAN_DIR_EN
   logic          lr_q;
   logic          ud_q;
`endif

   // Divider outputs are registered from the next count so they track cnt exactly, glitch-free.
   always_comb begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge CLK120 or negedge RST_N) begin
      if (!RST_N) begin
         cnt     <= '0;
         clk_pix <= 1'b0;
         pix_ce  <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         clk_pix <= (cnt_nxt >= CNT_HALF);
         pix_ce  <= (cnt_nxt == CNT_LAST);
      end
   end

   always_comb begin
      line_end  = (h == H_LAST);
      frame_top = (h == '0) && (v == '0);
      frame_end = line_end && (v == V_LAST);
      h_step    = line_end ? '0 : h + ONE;
      if (line_end) begin
         v_step = (v == V_LAST) ? '0 : v + ONE;
      end else begin
         v_step = v;
      end
      de_nxt = (h >= ONE) && (h <= H_ACT_C) && (v >= ONE) && (v <= V_ACT_C);
      hd_nxt = h - ONE;
      vd_nxt = v - ONE;
`ifdef TCON_SCAN_DIR_EN
      if (de_nxt && !lr_q) begin
         hd_nxt = H_ACT_C - h;
      end
      if (de_nxt && ud_q) begin
         vd_nxt = V_ACT_C - v;
      end
`endif
   end

`ifdef TCON_SCAN_DIR_EN
   // Direction is frozen per frame so a mid-frame LR/UD change never tears the image.
   always_ff @(posedge CLK120 or negedge RST_N) begin
      if (!RST_N) begin
         lr_q <= 1'b1;
         ud_q <= 1'b0;
      end else if (pix_ce && (state != IDLE) && frame_top) begin
         lr_q <= bus.LR;
         ud_q <= bus.UD;
      end
   end
`endif

   // Outputs decode the pre-update h/v, giving exactly one pixel tick of latency.
   always_ff @(posedge CLK120 or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         h           <= '0;
         v           <= '0;
         sth         <= 1'b0;
         oeh         <= 1'b0;
         ckv         <= 1'b0;
         stv         <= 1'b0;
         de          <= 1'b0;
         frame_start <= 1'b0;
         hdata       <= '0;
         vdata       <= '0;
      end else begin
         frame_start <= 1'b0;
         if (pix_ce) begin
            if (state == IDLE) begin
               sth   <= 1'b0;
               oeh   <= 1'b0;
               ckv   <= 1'b0;
               stv   <= 1'b0;
               de    <= 1'b0;
               hdata <= '0;
               vdata <= '0;
            end else begin
               sth         <= (h == '0);
               oeh         <= (h != H_LAST);
               ckv         <= (h == ONE);
               stv         <= (v == V_LAST);
               de          <= de_nxt;
               hdata       <= hd_nxt;
               vdata       <= vd_nxt;
               frame_start <= (state == RUN) && frame_top;
            end

            case (state)
               IDLE: begin
                  h <= '0;
                  v <= '0;
                  if (bus.EN) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  h <= h_step;
                  v <= v_step;
                  if (!bus.EN) begin
                     state <= DRAIN;
                  end
               end
               DRAIN: begin
                  h <= h_step;
                  v <= v_step;
                  if (bus.EN) begin
                     state <= RUN;
                  end else if (frame_end) begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
                  h     <= '0;
                  v     <= '0;
               end
            endcase
         end
      end
   end

   assign bus.CLK_PIX     = clk_pix;
   assign bus.PIX_CE      = pix_ce;
   assign bus.STH         = sth;
   assign bus.OEH         = oeh;
   assign bus.CKV         = ckv;
   assign bus.OEV         = ckv;
   assign bus.STV         = stv;
   assign bus.DE          = de;
   assign bus.FRAME_START = frame_start;
   assign bus.BUSY        = (state != IDLE);
   assign bus.hdata       = hdata;
   assign bus.vdata       = vdata;

endmodule

// File: tb/tb_tft_tcon_gen.sv
// tb/tb_tft_tcon_gen.sv - randomized self-checking bench for tft_tcon_gen against a frame-level model
module tb_tft_tcon_gen;
   localparam int DIV     = 3;
   localparam int H_TOTAL = 12;
   localparam int V_TOTAL = 6;
   localparam int H_ACT   = 10;
   localparam int V_ACT   = 5;
   localparam int CW      = 4;
   localparam int FRAME_CYC = DIV * H_TOTAL * V_TOTAL;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tft_tcon_gen_if #(.CW(CW)) bus();

   tft_tcon_gen #(
      .DIV(DIV), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
      .H_ACT(H_ACT), .V_ACT(V_ACT), .CW(CW)
   ) dut (
      .CLK120(clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 running, 2 finishing the frame after EN dropped.
   int            m_cnt, m_mode, m_h, m_v;
   bit            m_lr, m_ud;
   bit            e_sth, e_oeh, e_ckv, e_stv, e_de, e_fs;
   logic [CW-1:0] e_hd, e_vd;

   task automatic model_reset();
      m_cnt = 0; m_mode = 0; m_h = 0; m_v = 0;
      m_lr = 1'b1; m_ud = 1'b0;
      e_sth = 0; e_oeh = 0; e_ckv = 0; e_stv = 0; e_de = 0; e_fs = 0;
      e_hd = '0; e_vd = '0;
   endtask

   task automatic model_step();
      int  hx, vx;
      bit  last_px;
      e_fs = 0;
      if (m_cnt == DIV - 1) begin
         if (m_mode != 0) begin
            e_sth = (m_h == 0);
            e_oeh = (m_h != H_TOTAL - 1);
            e_ckv = (m_h == 1);
            e_stv = (m_v == V_TOTAL - 1);
            e_de  = (m_h >= 1 && m_h <= H_ACT && m_v >= 1 && m_v <= V_ACT);
            if (m_h == 0 && m_v == 0) begin
`ifdef TCON_SCAN_DIR_EN
               m_lr = bus.LR;
               m_ud = bus.UD;
`endif
               e_fs = (m_mode == 1);
            end
            hx = m_h - 1;
            vx = m_v - 1;
            if (e_de && !m_lr) hx = H_ACT - 1 - (m_h - 1);
            if (e_de && m_ud)  vx = V_ACT - 1 - (m_v - 1);
            e_hd = hx[CW-1:0];
            e_vd = vx[CW-1:0];
         end else begin
            e_sth = 0; e_oeh = 0; e_ckv = 0; e_stv = 0; e_de = 0;
            e_hd = '0; e_vd = '0;
         end
         last_px = (m_h == H_TOTAL - 1 && m_v == V_TOTAL - 1);
         if (m_mode != 0) begin
            m_h = m_h + 1;
            if (m_h == H_TOTAL) begin
               m_h = 0;
               m_v = (m_v + 1) % V_TOTAL;
            end
         end
         case (m_mode)
            0: if (bus.EN) m_mode = 1;
            1: if (!bus.EN) m_mode = 2;
            default: if (bus.EN) m_mode = 1; else if (last_px) m_mode = 0;
         endcase
      end
      m_cnt = (m_cnt + 1) % DIV;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   logic [9:0] obs_flags;
   assign obs_flags = {bus.CLK_PIX, bus.PIX_CE, bus.STH, bus.OEH, bus.CKV, bus.OEV,
                       bus.STV, bus.DE, bus.FRAME_START, bus.BUSY};

   function automatic logic [9:0] exp_flags();
      return {m_cnt >= DIV / 2, m_cnt == DIV - 1, e_sth, e_oeh, e_ckv, e_ckv,
              e_stv, e_de, e_fs, m_mode != 0};
   endfunction

   task automatic check_all();
      check("flags", 32'(obs_flags), 32'(exp_flags()));
      check("hdata", 32'(bus.hdata), 32'(e_hd));
      check("vdata", 32'(bus.vdata), 32'(e_vd));
   endtask

   // Frame-level monitor, enabled only while EN is held high without interruption.
   bit mon_on = 0;
   bit de_seen = 0;
   int fs_seen = 0;
   int tick_cnt, de_ticks, stv_ticks, oeh_low, ckv_ticks, sth_cyc;
`ifdef TCON_SCAN_DIR_EN
   localparam int FIRST_H = H_ACT - 1;
   localparam int FIRST_V = V_ACT - 1;
`else
   localparam int FIRST_H = 0;
   localparam int FIRST_V = 0;
`endif

   task automatic cycle();
      @(negedge clk);
      check_all();
      if (mon_on) begin
         if (bus.FRAME_START) begin
            if (fs_seen > 0) begin
               check("frame_period", 32'(tick_cnt), 32'(H_TOTAL * V_TOTAL));
               check("de_ticks",     32'(de_ticks), 32'(H_ACT * V_ACT));
               check("stv_ticks",    32'(stv_ticks), 32'(H_TOTAL));
               check("oeh_low",      32'(oeh_low), 32'(V_TOTAL));
               check("ckv_ticks",    32'(ckv_ticks), 32'(V_TOTAL));
               check("sth_cycles",   32'(sth_cyc), 32'(DIV * V_TOTAL));
            end
            fs_seen++;
            tick_cnt = 0; de_ticks = 0; stv_ticks = 0; oeh_low = 0; ckv_ticks = 0; sth_cyc = 0;
            de_seen = 0;
         end
         if (bus.STH) sth_cyc++;
         if (bus.PIX_CE) begin
            tick_cnt++;
            if (bus.DE)  de_ticks++;
            if (bus.STV) stv_ticks++;
            if (!bus.OEH) oeh_low++;
            if (bus.CKV) ckv_ticks++;
            if (bus.DE && !de_seen) begin
               de_seen = 1;
               check("first_px_h", 32'(bus.hdata), 32'(FIRST_H));
               check("first_px_v", 32'(bus.vdata), 32'(FIRST_V));
            end
         end
      end
   endtask

   // Called right after a falling clock edge; asserts reset mid-cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_flags", 32'(obs_flags), 32'd0);
      check("rst_hv", 32'({bus.hdata, bus.vdata}), 32'd0);
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int  n;
      bit  seen;
      bus.EN = 1'b0;
`ifdef TCON_SCAN_DIR_EN
      bus.LR = 1'b0;
      bus.UD = 1'b1;
`endif
      repeat (2) cycle();
      check("reset_busy", 32'(bus.BUSY), 32'd0);

      rst_n  = 1'b1;
      bus.EN = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < 4 * DIV) begin
         cycle();
         n++;
         seen = bus.PIX_CE;
      end
      check("first_ce_edge", 32'(n + 1), 32'(DIV));

      mon_on = 1;
      n = 0;
      while (fs_seen < 3 && n < 4 * FRAME_CYC) begin
         cycle();
         n++;
      end
      check("frames_seen", 32'(fs_seen), 32'd3);
      mon_on = 0;

      repeat (DIV * H_TOTAL * 2) cycle();
      bus.EN = 1'b0;
      n = 0;
      while (bus.BUSY && n < 2 * FRAME_CYC) begin
         cycle();
         n++;
      end
      check("drain_to_idle", 32'(bus.BUSY), 32'd0);
      repeat (2 * DIV) cycle();
      check("idle_outputs", 32'({obs_flags[7:0], bus.hdata, bus.vdata}), 32'd0);

      bus.EN = 1'b1;
      repeat (DIV * H_TOTAL * 3 + 5) cycle();
      do_reset();

      for (int i = 0; i < 20000; i++) begin
         int r;
         cycle();
         r = $urandom_range(0, 2499);
         if (r < 10) bus.EN = ~bus.EN;
`ifdef TCON_SCAN_DIR_EN
         if (r >= 100 && r < 112) bus.LR = ~bus.LR;
         if (r >= 200 && r < 212) bus.UD = ~bus.UD;
`endif
         if (r == 2499) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tft_tcon_gen.md
TFT_TCON_GEN -- requirements
Module: tft_tcon_gen

Interface
REQ-001 The block SHALL have the following parameters, one per line:
  - DIV, 12, CLK120 cycles per pixel; must be >= 2.
  - H_TOTAL, 482, pixel ticks per line.
  - V_TOTAL, 241, lines per frame.
  - H_ACT, 480, active pixels per line; must be <= H_TOTAL-2.
  - V_ACT, 240, active lines per frame; must be <= V_TOTAL-1.
  - CW, 9, counter and coordinate width; 2^CW must be >= max(H_TOTAL, V_TOTAL).
REQ-002 The block SHALL have the following ports, one per line:
  - CLK120, in, 1, sole clock; all logic on its rising edge.
  - RST_N, in, 1, asynchronous active-low reset.
  - EN, in, 1, run request.
  - LR, in, 1, horizontal scan direction; 1 = forward; present only with TCON_SCAN_DIR_EN.
  - UD, in, 1, vertical scan direction; 0 = forward; present only with TCON_SCAN_DIR_EN.
  - CLK_PIX, out, 1, pixel clock to the panel; also drives CPH1.
  - PIX_CE, out, 1, one-CLK120 pulse per pixel tick.
  - STH, out, 1, horizontal start pulse.
  - OEH, out, 1, source output enable.
  - CKV, out, 1, gate shift clock.
  - OEV, out, 1, gate output enable.
  - STV, out, 1, vertical start.
  - DE, out, 1, active-area flag.
  - FRAME_START, out, 1, one-CLK120 pulse at the start of each frame.
  - BUSY, out, 1, asserted while the state is not IDLE.
  - hdata, out, CW, pixel column coordinate.
  - vdata, out, CW, line coordinate.

Function
REQ-003 Divider: cnt SHALL run 0..DIV-1 and wrap to 0.
REQ-004 CLK_PIX SHALL be high for cnt >= DIV/2 (integer division).
REQ-005 PIX_CE SHALL be 1 exactly when cnt == DIV-1.
REQ-006 The divider SHALL free-run in every state.
REQ-007 FSM states SHALL be IDLE, RUN and DRAIN. All transitions SHALL occur only on PIX_CE cycles.
REQ-008 The FSM SHALL make the following transitions:
  - IDLE: EN=1 -> RUN.
  - RUN: EN=0 -> DRAIN.
  - DRAIN: EN=1 -> RUN.
  - DRAIN: at h == H_TOTAL-1 and v == V_TOTAL-1 -> IDLE.
REQ-009 Counters h and v SHALL behave as follows:
  - In RUN and DRAIN, h SHALL increment on PIX_CE.
  - h == H_TOTAL-1 -> h=0 and v increments.
  - v == V_TOTAL-1 at a line wrap -> v=0.
  - In IDLE, h and v SHALL be held at 0.
REQ-010 Decode SHALL be from h and v in RUN or DRAIN; all decoded flags SHALL be 0 in IDLE.
  - STH = (h == 0).
  - OEH = (h != H_TOTAL-1).
  - OEV = CKV = (h == 1).
  - STV = (v == V_TOTAL-1).
  - DE = (1 <= h <= H_ACT) and (1 <= v <= V_ACT).
REQ-011 All panel outputs, DE, hdata and vdata SHALL be registered on PIX_CE. Their latency SHALL be exactly one pixel tick after the counter values they decode.
REQ-012 Coordinates SHALL be hdata = (h-1) mod 2^CW and vdata = (v-1) mod 2^CW. Forward scan values are given here; mirroring is defined in REQ-017.
REQ-013 FRAME_START SHALL pulse on the PIX_CE at which h == 0 and v == 0 are first decoded in RUN, including the first frame after IDLE.
REQ-014 An EN change SHALL be sampled only on PIX_CE. A change on other CLK120 cycles SHALL have no effect until the next PIX_CE.

Reset
REQ-015 RST_N=0 SHALL immediately force the following state, regardless of any operation in progress mid-frame:
  - cnt = 0; h = 0; v = 0; state = IDLE.
  - All outputs 0; hdata and vdata 0.
REQ-016 After RST_N rises, the first PIX_CE SHALL occur on the DIV-th CLK120 rising edge.

Configuration
REQ-017 With TCON_SCAN_DIR_EN defined:
  - LR and UD SHALL be latched at each frame start (h == 0, v == 0 on PIX_CE).
  - While DE is set and latched LR=0, hdata SHALL equal H_ACT-1-(h-1).
  - While DE is set and latched UD=1, vdata SHALL equal V_ACT-1-(v-1).
  - Outside DE, coordinates SHALL follow REQ-012.
  - A mid-frame LR or UD change SHALL take effect only at the next frame.
REQ-018 Without TCON_SCAN_DIR_EN, the LR and UD ports SHALL be absent and scan SHALL be fixed forward (LR=1, UD=0).

Verification
REQ-019 Defaults, reset then EN=1 held:
  - The first PIX_CE SHALL occur on the 12th CLK120 edge.
  - STH=1 for exactly 12 CLK120 cycles, one pixel tick after h=0.
  - FRAME_START SHALL pulse once.
REQ-020 Line wrap: at h=481 -> 0, v SHALL increment.
  - OEH=0 for exactly one pixel tick per line.
  - OEV=CKV=1 for exactly one pixel tick per line.
REQ-021 Frame wrap at v=240, h=481:
  - STV SHALL be high for all 482 ticks of line 240.
  - v SHALL wrap to 0.
  - FRAME_START SHALL repeat every 482*241 = 116162 ticks.
  - DE SHALL be set for exactly 480*240 = 115200 ticks per frame.
REQ-022 EN=0 at v=100:
  - The frame SHALL complete through v=240, h=481.
  - BUSY SHALL then drop, and all outputs SHALL be 0.
  - EN re-asserted during DRAIN at v=200 SHALL return the FSM to RUN with no counter discontinuity.
REQ-023 RST_N pulsed low at v=57, h=300: all outputs and counters SHALL be 0 within the same CLK120 cycle, with no further PIX_CE until 12 edges after release.
REQ-024 With TCON_SCAN_DIR_EN, LR=0 and UD=1 latched:
  - At the first active pixel, hdata SHALL be 479 and vdata SHALL be 239.
  - An LR toggle mid-frame SHALL take effect only in the next frame.
